// File: rtl/program_control_stack.sv
// ---------------------------------------------------------------------------
// program_control_stack
//
// Front-end program-control unit: writable instruction memory, program
// counter, jump / jump-register / branch sequencing, a call/return address
// stack and a SUSPENDED / RUN / HALTED state machine.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   suspendEnable     1 = suspend the PC and allow memory writes
//   writeEnable       memory write strobe (only acts while SUSPENDED)
//   writeAddress      memory write address
//   writeInstruction  memory write data
//   jump              absolute jump to instruction[ADDR_WIDTH-1:0]
//   jumpReg           jump to jumpRegAddr[ADDR_WIDTH-1:0]
//   jumpRegAddr       register jump target
//   branch            conditional relative branch
//   negative          branch condition flag
//   call              push return address, jump to instruction[ADDR_WIDTH-1:0]
//   ret               pop return address into the PC
//   instruction       mem[pc], combinational read
//   pc                current program counter
//   stackCount        number of valid return-stack entries
//   stackOverflow     sticky: call issued while the stack was full
//   stackUnderflow    sticky: ret issued while the stack was empty
//   halted            high in the HALTED state
// ---------------------------------------------------------------------------
module program_control_stack #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 7,
    parameter int                    BR_OFF_WIDTH = 7,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = 32'hFFFFFFFF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               suspendEnable,
    input  logic                               writeEnable,
    input  logic [ADDR_WIDTH-1:0]              writeAddress,
    input  logic [DATA_WIDTH-1:0]              writeInstruction,
    input  logic                               jump,
    input  logic                               jumpReg,
    input  logic [DATA_WIDTH-1:0]              jumpRegAddr,
    input  logic                               branch,
    input  logic                               negative,
    input  logic                               call,
    input  logic                               ret,
    output logic [DATA_WIDTH-1:0]              instruction,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackCount,
    output logic                               stackOverflow,
    output logic                               stackUnderflow,
    output logic                               halted
);

    localparam int CNT_W     = $clog2(STACK_DEPTH + 1);
    localparam int SP_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_SUSPENDED = 2'd0,
        S_RUN       = 2'd1,
        S_HALTED    = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [DATA_WIDTH-1:0]    r_mem [0:MEM_DEPTH-1];
    logic [ADDR_WIDTH-1:0]    r_stack [0:STACK_DEPTH-1];

    logic [ADDR_WIDTH-1:0]    r_pc;
    logic [ADDR_WIDTH-1:0]    w_pc_next;
    logic [ADDR_WIDTH-1:0]    w_pc_inc;
    logic [ADDR_WIDTH-1:0]    w_br_target;
    logic signed [BR_OFF_WIDTH-1:0] w_br_off;

    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         w_count_next;
    logic [SP_W-1:0]          w_push_idx;
    logic [SP_W-1:0]          w_top_idx;
    logic                     w_push;

    logic                     r_ovf;
    logic                     r_unf;
    logic                     w_ovf_set;
    logic                     w_unf_set;

    // Only the low ADDR_WIDTH bits of the register target are meaningful.
    logic                     w_unused;
    assign w_unused = ^jumpRegAddr;

    assign instruction = r_mem[r_pc];

    // All PC arithmetic is modulo 2^ADDR_WIDTH; the size cast sign-extends
    // (or truncates) the branch offset to the PC width.
    assign w_pc_inc    = r_pc + ADDR_WIDTH'(1);
    assign w_br_off    = instruction[BR_OFF_WIDTH-1:0];
    assign w_br_target = w_pc_inc + ADDR_WIDTH'(w_br_off);

    // Push writes the slot just above the current top; pop reads the top.
    // Both are only used when the count guarantees the index is in range.
    assign w_push_idx  = SP_W'(r_count);
    assign w_top_idx   = SP_W'(r_count - CNT_W'(1));

    // Next-state, PC sequencing and stack control.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_count_next = r_count;
        w_push       = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;

        case (r_state)
            S_SUSPENDED: begin
                if (!suspendEnable) begin
                    w_state_next = S_RUN;
                end
            end

            S_RUN: begin
                if (suspendEnable) begin
                    w_state_next = S_SUSPENDED;
                end else if (instruction == HALT_WORD) begin
                    // Halt word freezes the PC; no control input acts.
                    w_state_next = S_HALTED;
                end else if (jumpReg) begin
                    w_pc_next = jumpRegAddr[ADDR_WIDTH-1:0];
                end else if (call) begin
                    if (r_count < CNT_W'(STACK_DEPTH)) begin
                        w_push       = 1'b1;
                        w_count_next = r_count + CNT_W'(1);
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                    w_pc_next = instruction[ADDR_WIDTH-1:0];
                end else if (ret) begin
                    if (r_count != '0) begin
                        w_pc_next    = r_stack[w_top_idx];
                        w_count_next = r_count - CNT_W'(1);
                    end else begin
                        w_pc_next = w_pc_inc;
                        w_unf_set = 1'b1;
                    end
                end else if (jump) begin
                    w_pc_next = instruction[ADDR_WIDTH-1:0];
                end else if (branch && negative) begin
                    w_pc_next = w_br_target;
                end else begin
                    w_pc_next = w_pc_inc;
                end
            end

            S_HALTED: begin
                if (suspendEnable) begin
                    w_state_next = S_SUSPENDED;
                    w_pc_next    = '0;
                end
            end

            default: begin
                w_state_next = S_SUSPENDED;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_SUSPENDED;
            r_pc    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    // Instruction memory: contents survive reset, writable only while
    // suspended.
    always_ff @(posedge clk) begin
        if ((r_state == S_SUSPENDED) && writeEnable) begin
            r_mem[writeAddress] <= writeInstruction;
        end
    end

    // Return-address storage; entries above the count are don't-care.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc             = r_pc;
    assign stackCount     = r_count;
    assign stackOverflow  = r_ovf;
    assign stackUnderflow = r_unf;
    assign halted         = (r_state == S_HALTED);

endmodule

// File: tb/tb_program_control_stack.sv
// ---------------------------------------------------------------------------
// tb_program_control_stack
//
// Self-checking bench: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model (array memory, queue
// stack, integer PC arithmetic).
// ---------------------------------------------------------------------------
module tb_program_control_stack;

    localparam int          DW    = 32;
    localparam int          AW    = 7;
    localparam int          DEPTH = 4;
    localparam int          NMEM  = 1 << AW;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          suspendEnable;
    logic          writeEnable;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeInstruction;
    logic          jump;
    logic          jumpReg;
    logic [DW-1:0] jumpRegAddr;
    logic          branch;
    logic          negative;
    logic          call;
    logic          ret;
    logic [DW-1:0] instruction;
    logic [AW-1:0] pc;
    logic [2:0]    stackCount;
    logic          stackOverflow;
    logic          stackUnderflow;
    logic          halted;

    program_control_stack #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BR_OFF_WIDTH(7),
        .STACK_DEPTH (DEPTH),
        .HALT_WORD   (HALT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .suspendEnable   (suspendEnable),
        .writeEnable     (writeEnable),
        .writeAddress    (writeAddress),
        .writeInstruction(writeInstruction),
        .jump            (jump),
        .jumpReg         (jumpReg),
        .jumpRegAddr     (jumpRegAddr),
        .branch          (branch),
        .negative        (negative),
        .call            (call),
        .ret             (ret),
        .instruction     (instruction),
        .pc              (pc),
        .stackCount      (stackCount),
        .stackOverflow   (stackOverflow),
        .stackUnderflow  (stackUnderflow),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state: 0 = suspended, 1 = run, 2 = halted.
    int          m_state;
    int          m_pc;
    logic [31:0] m_mem [NMEM];
    bit          m_known [NMEM];
    int          m_stack [$];
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % NMEM) + NMEM) % NMEM;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_stack.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One rising edge of the reference model, using the current inputs.
    task automatic model_step();
        logic [31:0] ins;
        int          off;
        case (m_state)
            0: begin
                if (writeEnable) begin
                    m_mem[writeAddress]   = writeInstruction;
                    m_known[writeAddress] = 1'b1;
                end
                if (!suspendEnable) m_state = 1;
            end
            1: begin
                ins = m_mem[m_pc];
                if (suspendEnable) m_state = 0;
                else if (ins == HALT) m_state = 2;
                else if (jumpReg) m_pc = int'(jumpRegAddr) & (NMEM - 1);
                else if (call) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(wrap(m_pc + 1));
                    else m_ovf = 1'b1;
                    m_pc = int'(ins) & (NMEM - 1);
                end else if (ret) begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin
                        m_pc  = wrap(m_pc + 1);
                        m_unf = 1'b1;
                    end
                end else if (jump) m_pc = int'(ins) & (NMEM - 1);
                else if (branch && negative) begin
                    off = int'(ins) & 127;
                    if (off >= 64) off -= 128;
                    m_pc = wrap(m_pc + 1 + off);
                end else m_pc = wrap(m_pc + 1);
            end
            default: begin
                if (suspendEnable) begin
                    m_state = 0;
                    m_pc    = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string where);
        check({where, ".pc"},     64'(pc),             64'(m_pc));
        check({where, ".count"},  64'(stackCount),     64'(m_stack.size()));
        check({where, ".ovf"},    64'(stackOverflow),  64'(m_ovf));
        check({where, ".unf"},    64'(stackUnderflow), 64'(m_unf));
        check({where, ".halted"}, 64'(halted),         64'(m_state == 2));
        if (m_known[m_pc]) check({where, ".instr"}, 64'(instruction), 64'(m_mem[m_pc]));
    endtask

    // One clock: model advances on the pre-edge inputs, DUT sampled 1 ns later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d: st=%0d pc=%0h cnt=%0d instr=%h", n_txn, m_state, pc, stackCount, instruction);
        check_outputs("cyc");
    endtask

    task automatic idle_ctrl();
        writeEnable = 1'b0;
        jump        = 1'b0;
        jumpReg     = 1'b0;
        branch      = 1'b0;
        negative    = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
    endtask

    task automatic jump_to(input int a);
        jumpReg     = 1'b1;
        jumpRegAddr = 32'(a);
        tick();
        jumpReg     = 1'b0;
    endtask

    int saved;

    initial begin
        reset            = 1'b0;
        suspendEnable    = 1'b1;
        writeAddress     = '0;
        writeInstruction = '0;
        jumpRegAddr      = '0;
        idle_ctrl();
        for (int k = 0; k < NMEM; k++) m_known[k] = 1'b0;
        model_reset();

        // Reset state.
        #3;
        check("rst.pc",     64'(pc),             64'd0);
        check("rst.count",  64'(stackCount),     64'd0);
        check("rst.ovf",    64'(stackOverflow),  64'd0);
        check("rst.unf",    64'(stackUnderflow), 64'd0);
        check("rst.halted", 64'(halted),         64'd0);
        #4;
        reset = 1'b1;

        // Load the memory while suspended.
        writeEnable = 1'b1;
        for (int k = 0; k < NMEM; k++) begin
            writeAddress     = AW'(k);
            writeInstruction = 32'h5ADFACED - 32'(k);
            tick();
        end
        writeEnable = 1'b0;

        // Run straight through the whole memory; PC wraps back to 0.
        suspendEnable = 1'b0;
        tick();
        for (int i = 0; i < NMEM; i++) begin
            tick();
            check("seq.instr", 64'(instruction), 64'(32'h5ADFACED - 32'((i + 1) % NMEM)));
        end
        check("wrap.pc",    64'(pc),          64'd0);
        check("wrap.instr", 64'(instruction), 64'h5ADFACED);

        // Write attempted in RUN is ignored.
        writeEnable      = 1'b1;
        writeAddress     = 7'd3;
        writeInstruction = 32'h0;
        tick();
        writeEnable = 1'b0;
        jump_to(3);
        suspendEnable = 1'b1;
        tick();
        check("runwr.mem3", 64'(instruction), 64'h5ADFACEA);

        // Program the call / branch targets while suspended.
        writeEnable = 1'b1;
        writeAddress = 7'd2; writeInstruction = 32'h12345640; tick();
        writeAddress = 7'd5; writeInstruction = 32'h0000007E; tick();
        writeAddress = 7'd0; writeInstruction = 32'h0000007F; tick();
        writeEnable = 1'b0;
        suspendEnable = 1'b0;
        tick();

        // Call / return.
        jump_to(2);
        call = 1'b1; tick(); call = 1'b0;
        check("call.pc",    64'(pc),         64'h40);
        check("call.count", 64'(stackCount), 64'd1);
        ret = 1'b1; tick(); ret = 1'b0;
        check("ret.pc",    64'(pc),         64'd3);
        check("ret.count", 64'(stackCount), 64'd0);

        // Nested calls past the stack depth, then unwind past empty.
        call = 1'b1;
        repeat (5) tick();
        call = 1'b0;
        check("ovf.flag",  64'(stackOverflow), 64'd1);
        check("ovf.count", 64'(stackCount),    64'd4);
        ret = 1'b1;
        repeat (4) tick();
        check("unf.early", 64'(stackUnderflow), 64'd0);
        saved = m_pc;
        tick();
        ret = 1'b0;
        check("unf.flag", 64'(stackUnderflow), 64'd1);
        check("unf.pc",   64'(pc),             64'(wrap(saved + 1)));

        // Branches.
        jump_to(5);
        branch = 1'b1; negative = 1'b1; tick(); branch = 1'b0; negative = 1'b0;
        check("br.back", 64'(pc), 64'd4);
        jump_to(5);
        branch = 1'b1; negative = 1'b0; tick(); branch = 1'b0;
        check("br.nottaken", 64'(pc), 64'd6);
        jump_to(0);
        branch = 1'b1; negative = 1'b1; tick(); branch = 1'b0; negative = 1'b0;
        check("br.self", 64'(pc), 64'd0);

        // Priority: jumpReg masks jump and call (no push).
        saved   = int'(stackCount);
        jumpReg = 1'b1; jump = 1'b1; call = 1'b1; jumpRegAddr = 32'h10;
        tick();
        idle_ctrl();
        check("prio.pc",    64'(pc),         64'h10);
        check("prio.count", 64'(stackCount), 64'(saved));

        // Halt word.
        suspendEnable = 1'b1;
        tick();
        writeEnable = 1'b1; writeAddress = 7'd9; writeInstruction = HALT; tick();
        writeEnable = 1'b0;
        suspendEnable = 1'b0;
        tick();
        jump_to(0);
        repeat (12) tick();
        jump = 1'b1;
        repeat (3) tick();
        jump = 1'b0;
        check("halt.pc",   64'(pc),     64'd9);
        check("halt.flag", 64'(halted), 64'd1);
        suspendEnable = 1'b1;
        tick();
        check("unhalt.pc",   64'(pc),     64'd0);
        check("unhalt.flag", 64'(halted), 64'd0);
        suspendEnable = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a clock period.
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst.pc",     64'(pc),             64'd0);
        check("arst.count",  64'(stackCount),     64'd0);
        check("arst.ovf",    64'(stackOverflow),  64'd0);
        check("arst.unf",    64'(stackUnderflow), 64'd0);
        check("arst.halted", 64'(halted),         64'd0);
        #1;
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (m_state == 0) suspendEnable = ($urandom_range(0, 1) == 0);
            else              suspendEnable = ($urandom_range(0, 19) == 0);
            writeEnable      = $urandom_range(0, 1) == 1;
            writeAddress     = AW'($urandom_range(0, NMEM - 1));
            writeInstruction = ($urandom_range(0, 7) == 0) ? HALT : 32'($urandom);
            jumpReg          = $urandom_range(0, 5) == 0;
            call             = $urandom_range(0, 4) == 0;
            ret              = $urandom_range(0, 4) == 0;
            jump             = $urandom_range(0, 5) == 0;
            branch           = $urandom_range(0, 2) == 0;
            negative         = $urandom_range(0, 1) == 1;
            jumpRegAddr      = 32'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_control_stack.md
Name: program_control_stack

Overview:
Parametrised next-generation program-control unit. It contains a writable instruction memory, the PC, jump/jump-register/branch sequencing, a call/return address stack of configurable depth, and a suspend/run/halt state machine. It sits at the front of the datapath and feeds instruction words to decode. Memory is loaded while suspended; instructions execute in RUN.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 7, PC/memory address width; memory depth = 2^ADDR_WIDTH words
BR_OFF_WIDTH, 7, width of the signed branch offset in instruction[BR_OFF_WIDTH-1:0]
STACK_DEPTH, 4, return-address stack entries (>=1)
HALT_WORD, 32'hFFFFFFFF, instruction value that halts the PC

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
suspendEnable  in  1  1 = suspend PC and allow memory writes
writeEnable  in  1  memory write strobe (honoured only in SUSPENDED)
writeAddress  in  ADDR_WIDTH  write address
writeInstruction  in  DATA_WIDTH  write data
jump  in  1  absolute jump to instruction[ADDR_WIDTH-1:0]
jumpReg  in  1  jump to jumpRegAddr[ADDR_WIDTH-1:0]
jumpRegAddr  in  DATA_WIDTH  register jump target
branch  in  1  conditional relative branch
negative  in  1  branch condition flag
call  in  1  push return address, jump to instruction[ADDR_WIDTH-1:0]
ret  in  1  pop return address into PC
instruction  out  DATA_WIDTH  mem[pc], combinational read
pc  out  ADDR_WIDTH  current PC
stackCount  out  $clog2(STACK_DEPTH+1)  valid stack entries
stackOverflow  out  1  sticky: call issued while stack full
stackUnderflow  out  1  sticky: ret issued while stack empty
halted  out  1  high in HALTED state

Behaviour:
- Reset (reset=0, asynchronous): pc=0, stackCount=0, stackOverflow=0, stackUnderflow=0, state=SUSPENDED, halted=0. Memory contents are not cleared.
- FSM states are SUSPENDED, RUN and HALTED. Transitions, evaluated on each rising clk:
  - SUSPENDED -> RUN when suspendEnable=0.
  - RUN -> SUSPENDED when suspendEnable=1. PC holds.
  - RUN -> HALTED when instruction==HALT_WORD. PC holds and no control input acts that cycle.
  - HALTED -> SUSPENDED when suspendEnable=1. PC is set to 0 on this edge.
  - HALTED otherwise holds pc and ignores all controls.
- Memory write: on a rising edge, when state=SUSPENDED && writeEnable=1, mem[writeAddress] <= writeInstruction. Writes in RUN or HALTED are ignored. A write to the address pc points at is visible on instruction after the edge.
- PC update in RUN only (suspendEnable=0 and not a halt word). The first matching rule wins:
  1. jumpReg: pc <= jumpRegAddr[ADDR_WIDTH-1:0].
  2. call: if stackCount<STACK_DEPTH, push pc+1 and increment stackCount. If full, there is no push and stackOverflow <= 1. In both cases pc <= instruction[ADDR_WIDTH-1:0].
  3. ret: if stackCount>0, pc <= top, pop, decrement stackCount. If empty, pc <= pc+1 and stackUnderflow <= 1.
  4. jump: pc <= instruction[ADDR_WIDTH-1:0].
  5. branch && negative: pc <= pc + 1 + sext(instruction[BR_OFF_WIDTH-1:0]).
  6. Otherwise pc <= pc+1.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH. pc+1 from the maximum address wraps to 0. Branch results wrap in both directions.
- A lower-priority control asserted together with a higher one has no effect. This includes stack side effects: a call masked by jumpReg does not push.
- A pushed return address is pc+1 modulo 2^ADDR_WIDTH.
- Stack is LIFO. Overflow and underflow flags are sticky until reset.
- Reset asserted mid-RUN acts immediately, with no clock required. After release, the block is in SUSPENDED with pc=0.

Test Plan:
- Load mem[k]=32'h5ADFACED-k for k=0..127 while suspended, then run 128 cycles -> instruction sequence 5ADFACED, 5ADFACEC, ...; pc wraps 127->0 and instruction returns to 5ADFACED.
- In RUN, write mem[3]=32'h0 with writeEnable=1 -> write ignored; a suspended reread of mem[3] gives the original value.
- mem[2] low bits=7'h40, call at pc=2 -> pc=0x40, stackCount=1. Then ret -> pc=3, stackCount=0. With STACK_DEPTH=4, five nested calls -> stackOverflow=1, stackCount=4. Five rets -> fifth ret sets stackUnderflow=1 and pc increments.
- Branch at pc=5 with offset field 7'h7E (-2) and negative=1 -> pc=4. Same with negative=0 -> pc=6. Offset 7'h7F at pc=0 -> pc=0.
- jumpReg=1, jump=1, call=1 together with jumpRegAddr=0x10 -> pc=0x10 and stackCount unchanged.
- mem[9]=HALT_WORD, run from 0 -> pc stops at 9, halted=1 regardless of jump. Then suspendEnable=1 -> SUSPENDED with pc=0, halted=0. Then reset=0 mid-RUN -> pc=0 immediately with flags cleared.
